// File: rtl/huffman_encoder.sv
// Static-table Huffman encoder: two nibble codes per byte,
// packed MSB-first into 16-bit words, flushed when enable drops.
module huffman_encoder (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        in_enable,
   input  logic [7:0]  data_in,
   output logic        out_valid,
   output logic [15:0] data_out,
   output logic        in_ready
);

   logic [31:0] acc_q, acc_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [15:0] dout_q, dout_d;
   logic        vld_q, vld_d;

   logic [8:0]  hi, lo;
   logic [11:0] byte_code;
   logic [4:0]  byte_len;
   logic [4:0]  total;
   logic [31:0] appended;

   // {length[2:0], code left-aligned in 6 bits}
   function automatic logic [8:0] nib_code(input logic [3:0] n);
      logic [8:0] r;
      unique case (n)
         4'd0:  r = {3'd2, 6'b000000};
         4'd1:  r = {3'd3, 6'b010000};
         4'd2:  r = {3'd3, 6'b011000};
         4'd3:  r = {3'd4, 6'b100000};
         4'd4:  r = {3'd4, 6'b100100};
         4'd5:  r = {3'd4, 6'b101000};
         4'd6:  r = {3'd4, 6'b101100};
         4'd7:  r = {3'd5, 6'b110000};
         4'd8:  r = {3'd5, 6'b110010};
         4'd9:  r = {3'd5, 6'b110100};
         4'd10: r = {3'd5, 6'b110110};
         4'd11: r = {3'd5, 6'b111000};
         4'd12: r = {3'd5, 6'b111010};
         4'd13: r = {3'd6, 6'b111100};
         4'd14: r = {3'd6, 6'b111101};
         4'd15: r = {3'd5, 6'b111110};
      endcase
      return r;
   endfunction

   assign in_ready  = enable && !rst;
   assign out_valid = vld_q;
   assign data_out  = dout_q;

   // Pending bits sit left-aligned in acc_q; bits below cnt_q stay zero.
   always_comb begin
      hi        = nib_code(data_in[7:4]);
      lo        = nib_code(data_in[3:0]);
      byte_code = {hi[5:0], 6'b0} | ({lo[5:0], 6'b0} >> hi[8:6]);
      byte_len  = {2'b0, hi[8:6]} + {2'b0, lo[8:6]};
      total     = cnt_q + byte_len;
      appended  = acc_q | ({byte_code, 20'b0} >> cnt_q);

      acc_d  = acc_q;
      cnt_d  = cnt_q;
      dout_d = dout_q;
      vld_d  = 1'b0;

      if (enable && in_enable) begin
         if (total >= 5'd16) begin
            dout_d = appended[31:16];
            acc_d  = {appended[15:0], 16'b0};
            cnt_d  = total - 5'd16;
            vld_d  = 1'b1;
         end else begin
            acc_d = appended;
            cnt_d = total;
         end
      end else if (!enable && cnt_q != 5'd0) begin
         dout_d = acc_q[31:16];
         acc_d  = 32'b0;
         cnt_d  = 5'd0;
         vld_d  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q  <= 32'b0;
         cnt_q  <= 5'd0;
         dout_q <= 16'h0000;
         vld_q  <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         cnt_q  <= cnt_d;
         dout_q <= dout_d;
         vld_q  <= vld_d;
      end
   end

endmodule

// File: tb/tb_huffman_encoder.sv
// Directed bench for huffman_encoder with hand-computed words.
module tb_huffman_encoder;

   logic        clk;
   logic        rst;
   logic        enable;
   logic        in_enable;
   logic [7:0]  data_in;
   logic        out_valid;
   logic [15:0] data_out;
   logic        in_ready;

   int tests;
   int failed;
   int words;

   huffman_encoder dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .in_enable (in_enable),
      .data_in   (data_in),
      .out_valid (out_valid),
      .data_out  (data_out),
      .in_ready  (in_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] vmask;
      tests     = 0;
      failed    = 0;
      rst       = 1'b1;
      enable    = 1'b0;
      in_enable = 1'b0;
      data_in   = 8'h00;
      tick();
      tick();
      chk("rst_vld", {31'b0, out_valid}, 32'd0);
      chk("rst_dout", {16'b0, data_out}, 32'h0000);
      enable = 1'b1;
      #1;
      chk("rst_rdy", {31'b0, in_ready}, 32'd0);
      rst = 1'b0;
      #1;
      chk("rdy_on", {31'b0, in_ready}, 32'd1);

      // 05 44 32 -> 2A66, then flush 1800
      in_enable = 1'b1;
      data_in   = 8'h05;
      tick();
      chk("t1_b0_vld", {31'b0, out_valid}, 32'd0);
      data_in = 8'h44;
      tick();
      chk("t1_b1_vld", {31'b0, out_valid}, 32'd0);
      data_in = 8'h32;
      tick();
      chk("t1_vld", {31'b0, out_valid}, 32'd1);
      chk("t1_word", {16'b0, data_out}, 32'h2A66);
      in_enable = 1'b0;
      tick();
      chk("t1_idle_vld", {31'b0, out_valid}, 32'd0);
      chk("t1_hold", {16'b0, data_out}, 32'h2A66);
      enable = 1'b0;
      tick();
      chk("t1_fl_vld", {31'b0, out_valid}, 32'd1);
      chk("t1_flush", {16'b0, data_out}, 32'h1800);
      tick();
      chk("t1_once", {31'b0, out_valid}, 32'd0);

      // single FF -> flush FFC0
      enable    = 1'b1;
      in_enable = 1'b1;
      data_in   = 8'hFF;
      tick();
      chk("t2_vld", {31'b0, out_valid}, 32'd0);
      enable    = 1'b0;
      in_enable = 1'b0;
      tick();
      chk("t2_fl_vld", {31'b0, out_valid}, 32'd1);
      chk("t2_flush", {16'b0, data_out}, 32'hFFC0);
      tick();
      chk("t2_once", {31'b0, out_valid}, 32'd0);

      // FF FF -> FFFF, flush F000
      enable    = 1'b1;
      in_enable = 1'b1;
      tick();
      chk("t3_b0_vld", {31'b0, out_valid}, 32'd0);
      tick();
      chk("t3_vld", {31'b0, out_valid}, 32'd1);
      chk("t3_word", {16'b0, data_out}, 32'hFFFF);
      enable    = 1'b0;
      in_enable = 1'b0;
      tick();
      chk("t3_fl_vld", {31'b0, out_valid}, 32'd1);
      chk("t3_flush", {16'b0, data_out}, 32'hF000);

      // 8 x FF = 80 bits -> 5 words, nothing left
      vmask     = 8'b1101_1010;
      words     = 0;
      enable    = 1'b1;
      in_enable = 1'b1;
      data_in   = 8'hFF;
      for (int k = 0; k < 8; k++) begin
         tick();
         chk($sformatf("t4_vld%0d", k), {31'b0, out_valid},
             {31'b0, vmask[k]});
         if (out_valid) begin
            words++;
            chk($sformatf("t4_w%0d", k), {16'b0, data_out}, 32'hFFFF);
         end
      end
      chk("t4_words", words, 32'd5);
      enable    = 1'b0;
      in_enable = 1'b0;
      tick();
      chk("t4_noflush", {31'b0, out_valid}, 32'd0);

      // enable=0 ignores input
      in_enable = 1'b1;
      for (int k = 0; k < 3; k++) begin
         data_in = 8'h3C + 8'(k * 17);
         #1;
         chk($sformatf("t5_rdy%0d", k), {31'b0, in_ready}, 32'd0);
         tick();
         chk($sformatf("t5_vld%0d", k), {31'b0, out_valid}, 32'd0);
      end
      enable    = 1'b1;
      in_enable = 1'b0;
      tick();
      enable = 1'b0;
      tick();
      chk("t5_nopend", {31'b0, out_valid}, 32'd0);

      // reset with pending bits discards them
      enable    = 1'b1;
      in_enable = 1'b1;
      data_in   = 8'h05;
      tick();
      rst = 1'b1;
      tick();
      chk("t6_rst_vld", {31'b0, out_valid}, 32'd0);
      chk("t6_rst_dout", {16'b0, data_out}, 32'h0000);
      rst       = 1'b0;
      enable    = 1'b0;
      in_enable = 1'b0;
      tick();
      chk("t6_noflush", {31'b0, out_valid}, 32'd0);
      enable    = 1'b1;
      in_enable = 1'b1;
      data_in   = 8'hFF;
      tick();
      tick();
      chk("t6_vld", {31'b0, out_valid}, 32'd1);
      chk("t6_word", {16'b0, data_out}, 32'hFFFF);
      enable    = 1'b0;
      in_enable = 1'b0;
      tick();
      chk("t6_flush", {16'b0, data_out}, 32'hF000);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
